// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter family.
// Holds the arbiter state encoding, index-width helper and default data width.
package arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int DEFAULT_DATA_W = 8;

    // Index width for n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping modulo N_REQ, found with a doubled-vector priority scan.
module rr_pick
    import arbiter_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]        req,
    input  logic [idx_w(N_REQ)-1:0] ptr,
    output logic [idx_w(N_REQ)-1:0] winner,
    output logic                    found
);

    localparam int IW = idx_w(N_REQ);

    logic [N_REQ-1:0] rot;
    logic [IW-1:0]    off;
    logic [IW:0]      sum;

    // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        // Rotating the doubled vector puts requester ptr at bit 0.
        rot   = N_REQ'({req, req} >> ptr);
        found = |rot;
        off   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IW'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IW + 1)'(N_REQ)) begin
            winner = IW'(sum - (IW + 1)'(N_REQ));
        end else begin
            winner = IW'(sum);
        end
    end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter with grant hold, hold-timeout pre-emption and
// registered forwarding of the granted requester's data word.
module rr_arbiter_n
    import arbiter_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int MAX_HOLD = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   data,
    output logic [N_REQ-1:0]          gnt,
    output logic                      gnt_valid,
    output logic [idx_w(N_REQ)-1:0]   gnt_id,
    output logic [DATA_W-1:0]         data_out,
    output logic                      preempt
);

    localparam int IW    = idx_w(N_REQ);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    arb_state_e         state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [IW-1:0]      gnt_id_q, gnt_id_d;
    logic [DATA_W-1:0]  data_out_q, data_out_d;
    logic               preempt_q, preempt_d;

    logic [IW-1:0]      winner;
    logic               found;
    logic [N_REQ-1:0]   others;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (winner),
        .found  (found)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_id_d  = gnt_id_q;
        preempt_d = 1'b0;
        others    = req & ~gnt_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d  = GRANT;
                    gnt_id_d = winner;
                    ptr_d    = (winner == IW'(N_REQ - 1)) ? '0 : winner + 1'b1;
                    cnt_d    = CNT_W'(1);
                end
            end
            GRANT: begin
                if (!req[gnt_id_q]) begin
                    state_d  = IDLE;
                    gnt_id_d = '0;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_W'(MAX_HOLD) && |others) begin
                    state_d   = IDLE;
                    gnt_id_d  = '0;
                    cnt_d     = '0;
                    preempt_d = 1'b1;
                end else if (cnt_q != CNT_W'(MAX_HOLD)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_id_d = '0;
                cnt_d    = '0;
            end
        endcase

        // Outputs are derived from the next state so they register alongside it.
        gnt_valid_d = (state_d == GRANT);
        gnt_d       = gnt_valid_d ? (N_REQ'(1) << gnt_id_d) : '0;
        data_out_d  = gnt_valid_d ? data[int'(gnt_id_d)*DATA_W +: DATA_W] : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            data_out_q  <= '0;
            preempt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            data_out_q  <= data_out_d;
            preempt_q   <= preempt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;
    assign data_out  = data_out_q;
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Self-checking bench for rr_arbiter_n: directed vector table, hand-written
// timeout/hold/reset sequences, and random traffic against a reference model.
module tb_rr_arbiter_n;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MH = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic [N-1:0]      req;
    logic [N*DW-1:0]   data;
    logic [N-1:0]      gnt;
    logic              gnt_valid;
    logic [1:0]        gnt_id;
    logic [DW-1:0]     data_out;
    logic              preempt;

    rr_arbiter_n #(
        .N_REQ    (N),
        .DATA_W   (DW),
        .MAX_HOLD (MH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .data      (data),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .data_out  (data_out),
        .preempt   (preempt)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: owner of the bus (-1 = none), next-priority index,
    // cycles the current owner has held, and the expected pulse/data.
    int          m_owner = -1;
    int          m_ptr   = 0;
    int          m_hold  = 0;
    logic        m_pre   = 1'b0;
    logic [DW-1:0] m_dout = '0;

    typedef struct {
        logic          rst;
        logic [N-1:0]  req;
        logic [N-1:0]  gnt;
        logic [1:0]    id;
        logic [DW-1:0] dout;
        logic          pre;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] rest;
        m_pre = 1'b0;
        if (reset) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (req[i]) begin
                    m_owner = i;
                    m_ptr   = (i + 1) % N;
                    m_hold  = 1;
                    break;
                end
            end
        end else if (!req[m_owner]) begin
            m_owner = -1;
        end else begin
            rest = req;
            rest[m_owner] = 1'b0;
            if (m_hold >= MH && rest != '0) begin
                m_owner = -1;
                m_pre   = 1'b1;
            end else if (m_hold < MH) begin
                m_hold++;
            end
        end
        m_dout = (m_owner >= 0) ? data[m_owner*DW +: DW] : '0;
    endtask

    // Apply inputs, advance one edge, update the model, settle before sampling.
    task automatic step(input logic rst, input logic [N-1:0] r);
        reset = rst;
        req   = r;
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0] eg;
        eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        check({tag, " gnt"},       gnt, eg);
        check({tag, " gnt_valid"}, gnt_valid, |eg);
        check({tag, " gnt_id"},    gnt_id, (m_owner >= 0) ? m_owner : 0);
        check({tag, " data_out"},  data_out, m_dout);
        check({tag, " preempt"},   preempt, m_pre);
    endtask

    initial begin
        int bad;
        logic [N-1:0] cur;

        reset = 1'b1;
        req   = '0;
        data  = 32'hD4C3_B2A1;

        // Reset with all requesting, release-driven rotation 0,1,2,3,0 and wrap from pointer 3.
        vecs.push_back(vec_t'{1'b1, 4'b1111, 4'b0000, 2'd0, 8'h00, 1'b0});
        vecs.push_back(vec_t'{1'b1, 4'b1111, 4'b0000, 2'd0, 8'h00, 1'b0});
        vecs.push_back(vec_t'{1'b0, 4'b1111, 4'b0001, 2'd0, 8'hA1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 4'b1111, 4'b0001, 2'd0, 8'hA1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 4'b1111, 4'b0001, 2'd0, 8'hA1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 4'b1110, 4'b0000, 2'd0, 8'h00, 1'b0});
        vecs.push_back(vec_t'{1'b0, 4'b1110, 4'b0010, 2'd1, 8'hB2, 1'b0});
        vecs.push_back(vec_t'{1'b0, 4'b1110, 4'b0010, 2'd1, 8'hB2, 1'b0});
        vecs.push_back(vec_t'{1'b0, 4'b1110, 4'b0010, 2'd1, 8'hB2, 1'b0});
        vecs.push_back(vec_t'{1'b0, 4'b1100, 4'b0000, 2'd0, 8'h00, 1'b0});
        vecs.push_back(vec_t'{1'b0, 4'b1100, 4'b0100, 2'd2, 8'hC3, 1'b0});
        vecs.push_back(vec_t'{1'b0, 4'b1100, 4'b0100, 2'd2, 8'hC3, 1'b0});
        vecs.push_back(vec_t'{1'b0, 4'b1100, 4'b0100, 2'd2, 8'hC3, 1'b0});
        vecs.push_back(vec_t'{1'b0, 4'b1001, 4'b0000, 2'd0, 8'h00, 1'b0});
        vecs.push_back(vec_t'{1'b0, 4'b1001, 4'b1000, 2'd3, 8'hD4, 1'b0});
        vecs.push_back(vec_t'{1'b0, 4'b1001, 4'b1000, 2'd3, 8'hD4, 1'b0});
        vecs.push_back(vec_t'{1'b0, 4'b1001, 4'b1000, 2'd3, 8'hD4, 1'b0});
        vecs.push_back(vec_t'{1'b0, 4'b0001, 4'b0000, 2'd0, 8'h00, 1'b0});
        vecs.push_back(vec_t'{1'b0, 4'b0001, 4'b0001, 2'd0, 8'hA1, 1'b0});

        for (int v = 0; v < vecs.size(); v++) begin
            step(vecs[v].rst, vecs[v].req);
            check($sformatf("vec%0d gnt", v),       gnt, vecs[v].gnt);
            check($sformatf("vec%0d gnt_valid", v), gnt_valid, |vecs[v].gnt);
            check($sformatf("vec%0d gnt_id", v),    gnt_id, vecs[v].id);
            check($sformatf("vec%0d data_out", v),  data_out, vecs[v].dout);
            check($sformatf("vec%0d preempt", v),   preempt, vecs[v].pre);
        end

        // data_out follows a data change on the granted slice one cycle later.
        data[7:0] = 8'h5A;
        step(1'b0, 4'b0001);
        check("data_lag data_out", data_out, 8'h5A);

        // Timeout: requester 0 holds 16 cycles, then pre-empted in favour of 1.
        step(1'b1, 4'b0000);
        bad = 0;
        for (int c = 0; c < MH; c++) begin
            step(1'b0, 4'b0011);
            if (gnt !== 4'b0001 || preempt !== 1'b0) bad++;
        end
        check("timeout held_cycles_bad", bad, 0);
        step(1'b0, 4'b0011);
        check("timeout revoke gnt", gnt, 4'b0000);
        check("timeout revoke preempt", preempt, 1'b1);
        step(1'b0, 4'b0011);
        check("timeout next gnt", gnt, 4'b0010);
        check("timeout next preempt", preempt, 1'b0);

        // Lone requester holds past MAX_HOLD without pre-emption.
        step(1'b1, 4'b0000);
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            step(1'b0, 4'b0100);
            if (gnt !== 4'b0100 || preempt !== 1'b0) bad++;
        end
        check("lone bad_cycles", bad, 0);

        // Reset mid-grant clears outputs and the pointer.
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0010);
        step(1'b0, 4'b0010);
        check("midreset pre gnt", gnt, 4'b0010);
        step(1'b1, 4'b0010);
        check("midreset gnt", gnt, 4'b0000);
        check("midreset gnt_valid", gnt_valid, 1'b0);
        check("midreset gnt_id", gnt_id, 2'd0);
        check("midreset data_out", data_out, 8'h00);
        check("midreset preempt", preempt, 1'b0);
        step(1'b0, 4'b0110);
        check("midreset regrant gnt", gnt, 4'b0010);

        // Random traffic with sticky requests so long holds and timeouts occur.
        step(1'b1, 4'b0000);
        cur = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(5) == 0) cur[b] = ~cur[b];
            end
            data = $urandom;
            step(($urandom_range(255) == 0), cur);
            check_model($sformatf("rand%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
